// File: rtl/keypad_entry_scanner.sv
// 4x4 matrix keypad scanner with per-scan debounce and 4-digit BCD entry assembly.
// Optional auto-repeat of a held key is enabled with `define KEYPAD_REPEAT_EN.
module keypad_entry_scanner #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 8,
    parameter int unsigned REPEAT_DELAY   = 100,
    parameter int unsigned REPEAT_RATE    = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] entry_bcd,
    output logic        entry_valid
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [7:0] DbScans = 8'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StRelDb} state_e;

    state_e          state_q, state_d;
    logic [3:0]      row_meta_q, row_sync_q;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      col_q, col_d;
    logic [1:0]      hit_cnt_q, hit_cnt_d;
    logic [3:0]      hit_pos_q, hit_pos_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      key_q, key_d;
    logic            accept;

    logic       dwell_end, scan_end;
    logic [3:0] col_hits;
    logic [2:0] n_col, tot;
    logic [1:0] hit_row, tot_sat;
    logic       cand_key;
    logic [3:0] cand_pos, cand_code;

    // pos = {row, col}
    function automatic logic [3:0] key_of(input logic [3:0] pos);
        logic [3:0] code;
        unique case (pos)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = 4'd14;
            4'd13:   code = 4'd0;
            4'd14:   code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    assign col_n     = ~(4'b0001 << col_q);
    assign dwell_end = (div_q == DivLast);
    assign scan_end  = dwell_end && (col_q == 2'd3);

    // Candidate accumulation: intersections seen so far this scan, saturating at 2.
    always_comb begin
        col_hits = ~row_sync_q;
        n_col    = 3'(col_hits[0]) + 3'(col_hits[1]) + 3'(col_hits[2]) + 3'(col_hits[3]);
        if (col_hits[0])      hit_row = 2'd0;
        else if (col_hits[1]) hit_row = 2'd1;
        else if (col_hits[2]) hit_row = 2'd2;
        else                  hit_row = 2'd3;
        tot       = {1'b0, hit_cnt_q} + n_col;
        tot_sat   = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        cand_key  = (tot_sat == 2'd1);
        cand_pos  = (n_col == 3'd1) ? {hit_row, col_q} : hit_pos_q;
        cand_code = key_of(cand_pos);

        div_d     = dwell_end ? '0 : div_q + 1'b1;
        col_d     = dwell_end ? col_q + 2'd1 : col_q;
        hit_cnt_d = hit_cnt_q;
        hit_pos_d = hit_pos_q;
        if (dwell_end) begin
            hit_cnt_d = scan_end ? 2'd0 : tot_sat;
            if (n_col == 3'd1) hit_pos_d = {hit_row, col_q};
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rep_cnt_q, rep_cnt_d;
    logic        rep_phase_q, rep_phase_d, rep_stop_q, rep_stop_d;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        accept  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_stop_d  = rep_stop_q;
`endif
        if (scan_end) begin
            unique case (state_q)
                StIdle: begin
                    if (cand_key) begin
                        key_d = cand_code;
                        cnt_d = 8'd1;
                        if (DbScans == 8'd1) begin
                            state_d = StHeld;
                            accept  = 1'b1;
                        end else begin
                            state_d = StPressDb;
                        end
                    end
                end
                StPressDb: begin
                    if (cand_key && cand_code == key_q) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == DbScans) begin
                            state_d = StHeld;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end
                end
                StHeld: begin
                    if (!cand_key) begin
                        cnt_d   = (DbScans == 8'd1) ? 8'd0 : 8'd1;
                        state_d = (DbScans == 8'd1) ? StIdle : StRelDb;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (cand_code != key_q) begin
                        rep_stop_d = 1'b1;
                    end else if (!rep_stop_q) begin
                        rep_cnt_d = rep_cnt_q + 16'd1;
                        if ((!rep_phase_q && rep_cnt_d == 16'(REPEAT_DELAY)) ||
                            (rep_phase_q && rep_cnt_d == 16'(REPEAT_RATE))) begin
                            accept      = 1'b1;
                            rep_cnt_d   = 16'd0;
                            rep_phase_d = 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    if (!cand_key) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == DbScans) begin
                            state_d = StIdle;
                            cnt_d   = 8'd0;
                        end
                    end else begin
                        state_d = StHeld;
                        cnt_d   = 8'd0;
                    end
                end
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        if (state_d != StHeld) begin
            rep_cnt_d   = 16'd0;
            rep_phase_d = 1'b0;
            rep_stop_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            col_q       <= 2'd0;
            hit_cnt_q   <= 2'd0;
            hit_pos_q   <= 4'd0;
            cnt_q       <= 8'd0;
            key_q       <= 4'd0;
            key_valid   <= 1'b0;
            key_code    <= 4'd0;
            entry_bcd   <= 16'd0;
            entry_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_meta_q  <= row_n;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            col_q       <= col_d;
            hit_cnt_q   <= hit_cnt_d;
            hit_pos_q   <= hit_pos_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid   <= accept;
            entry_valid <= accept && (key_d == 4'd15);
            if (accept) begin
                key_code <= key_d;
                if (key_d <= 4'd9)       entry_bcd <= {entry_bcd[11:0], key_d};
                else if (key_d == 4'd14) entry_bcd <= 16'd0;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= 16'd0;
            rep_phase_q <= 1'b0;
            rep_stop_q  <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            rep_stop_q  <= rep_stop_d;
        end
    end
`endif

endmodule
